// File: rtl/adpll_mod_serializer_pkg.sv
// Shared constants, register map and types for the ADPLL modulation serializer.
package adpll_mod_serializer_pkg;

    localparam int unsigned MOD_ADDR_W  = 5;
    localparam int unsigned MOD_FIFO_AW = 3;
    localparam int unsigned MOD_DIV_W   = 8;

    // Register word addresses
    localparam int unsigned MOD_TX_DATA   = 0;
    localparam int unsigned MOD_TX_DIV    = 1;
    localparam int unsigned MOD_TX_EN     = 2;
    localparam int unsigned MOD_TX_STATUS = 3;
    localparam int unsigned MOD_TX_CTRL   = 4;
    localparam int unsigned MOD_TX_IDLE   = 5;

    // TX_STATUS bit positions
    localparam int unsigned STAT_BUSY      = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_EMPTY     = 2;
    localparam int unsigned STAT_UNDERRUN  = 3;
    localparam int unsigned STAT_OVERFLOW  = 4;
    localparam int unsigned STAT_LEVEL_LSB = 8;

    // TX_CTRL bit positions
    localparam int unsigned MOD_CTRL_FLUSH = 0;
    localparam int unsigned MOD_CTRL_CLR   = 1;

    localparam logic [31:0] MOD_RD_INVALID = 32'hFFFF_FFFF;
    localparam int unsigned MOD_TX_DIV_RST = 31;

    typedef enum logic [0:0] {
        TX_ST_IDLE  = 1'b0,
        TX_ST_SHIFT = 1'b1
    } tx_state_e;

    // Decoded write strobes for one CPU access
    typedef struct packed {
        logic push;
        logic wr_div;
        logic wr_en;
        logic wr_idle;
        logic flush;
        logic clr_sticky;
    } reg_wr_t;

    function automatic reg_wr_t decode_write(input logic wr, input logic [31:0] addr,
                                             input logic [1:0] ctrl);
        reg_wr_t r;
        r = '0;
        if (wr) begin
            case (addr)
                MOD_TX_DATA: r.push    = 1'b1;
                MOD_TX_DIV:  r.wr_div  = 1'b1;
                MOD_TX_EN:   r.wr_en   = 1'b1;
                MOD_TX_IDLE: r.wr_idle = 1'b1;
                MOD_TX_CTRL: begin
                    r.flush      = ctrl[MOD_CTRL_FLUSH];
                    r.clr_sticky = ctrl[MOD_CTRL_CLR];
                end
                default: ;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/adpll_mod_serializer_if.sv
// CPU register-bus interface for the modulation serializer.
interface adpll_mod_serializer_if
    import adpll_mod_serializer_pkg::*;
#(
    parameter int unsigned ADDR_W = MOD_ADDR_W
);
    logic              valid;
    logic [ADDR_W-1:0] address;
    logic [31:0]       wdata;
    logic              wstrb;
    logic [31:0]       rdata;
    logic              ready;

    modport master (output valid, address, wdata, wstrb, input rdata, ready);
    modport slave  (input valid, address, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/adpll_mod_fifo.sv
// Synchronous byte FIFO with push/pop/flush; a push into a full FIFO is dropped.
module adpll_mod_fifo
    import adpll_mod_serializer_pkg::*;
#(
    parameter int unsigned AW = MOD_FIFO_AW
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [7:0]  wdata,
    output logic [7:0]  head_c,
    output logic        full_c,
    output logic        empty_c,
    output logic        drop_c,
    output logic [AW:0] level
);
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned LW    = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push;
    logic          do_pop;

    assign full_c  = (level_q == LW'(DEPTH));
    assign empty_c = (level_q == '0);
    assign head_c  = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Pointer/level update; flush overrides everything and discards a same-cycle push
    always_comb begin
        do_push  = push && !full_c && !flush;
        do_pop   = pop && !empty_c;
        drop_c   = push && full_c && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    // Pointer and level registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Byte storage, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/adpll_mod_serializer.sv
// CPU-programmable LSB-first modulation bit-stream generator for the ADPLL data_mod input.
module adpll_mod_serializer
    import adpll_mod_serializer_pkg::*;
#(
    parameter int unsigned ADDR_W  = MOD_ADDR_W,
    parameter int unsigned FIFO_AW = MOD_FIFO_AW,
    parameter int unsigned DIV_W   = MOD_DIV_W
) (
    input  logic                   clk,
    input  logic                   rst,
    adpll_mod_serializer_if.slave  bus,
    output logic                   data_mod,
    output logic                   bit_strobe
);
    reg_wr_t          wr_c;
    tx_state_e        state_q, state_d;
    logic [DIV_W-1:0] tx_div_q, tx_div_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             tx_en_q, tx_en_d;
    logic             tx_idle_q, tx_idle_d;
    logic             underrun_q, underrun_d;
    logic             overflow_q, overflow_d;
    logic             data_mod_q, data_mod_d;
    logic             bit_strobe_q, bit_strobe_d;
    logic             ready_q;
    logic             pop_c;
    logic             underrun_set_c;
    logic             busy_c;
    logic [31:0]      status_c;
    logic [31:0]      rdata_c;
    logic [7:0]       fifo_head_c;
    logic             fifo_full_c;
    logic             fifo_empty_c;
    logic             fifo_drop_c;
    logic [FIFO_AW:0] fifo_level;
    logic             unused_wdata;

    assign unused_wdata = ^bus.wdata;

    adpll_mod_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_c.push),
        .pop     (pop_c),
        .flush   (wr_c.flush),
        .wdata   (bus.wdata[7:0]),
        .head_c  (fifo_head_c),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c),
        .drop_c  (fifo_drop_c),
        .level   (fifo_level)
    );

    // Register writes and sticky flags; a set event beats a same-cycle clear
    always_comb begin
        wr_c       = decode_write(bus.valid && bus.wstrb, 32'(bus.address), bus.wdata[1:0]);
        tx_div_d   = wr_c.wr_div  ? bus.wdata[DIV_W-1:0] : tx_div_q;
        tx_en_d    = wr_c.wr_en   ? bus.wdata[0] : tx_en_q;
        tx_idle_d  = wr_c.wr_idle ? bus.wdata[0] : tx_idle_q;
        underrun_d = underrun_set_c | (underrun_q & ~wr_c.clr_sticky);
        overflow_d = fifo_drop_c    | (overflow_q & ~wr_c.clr_sticky);
    end

    // Serializer next-state: load a byte, shift on each bit period, chain bytes seamlessly
    always_comb begin
        state_d        = state_q;
        div_cnt_d      = div_cnt_q;
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        data_mod_d     = data_mod_q;
        bit_strobe_d   = 1'b0;
        pop_c          = 1'b0;
        underrun_set_c = 1'b0;
        case (state_q)
            TX_ST_IDLE: begin
                data_mod_d = tx_idle_q;
                if (tx_en_q && !fifo_empty_c) begin
                    pop_c        = 1'b1;
                    shift_d      = fifo_head_c;
                    data_mod_d   = fifo_head_c[0];
                    bit_cnt_d    = '0;
                    div_cnt_d    = '0;
                    bit_strobe_d = 1'b1;
                    state_d      = TX_ST_SHIFT;
                end
            end
            TX_ST_SHIFT: begin
                if (div_cnt_q >= tx_div_q) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q != 3'd7) begin
                        shift_d      = {1'b0, shift_q[7:1]};
                        data_mod_d   = shift_q[1];
                        bit_cnt_d    = bit_cnt_q + 3'd1;
                        bit_strobe_d = 1'b1;
                    end else if (tx_en_q && !fifo_empty_c) begin
                        pop_c        = 1'b1;
                        shift_d      = fifo_head_c;
                        data_mod_d   = fifo_head_c[0];
                        bit_cnt_d    = '0;
                        bit_strobe_d = 1'b1;
                    end else begin
                        underrun_set_c = tx_en_q;
                        data_mod_d     = tx_idle_q;
                        state_d        = TX_ST_IDLE;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: state_d = TX_ST_IDLE;
        endcase
    end

    // All state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= TX_ST_IDLE;
            tx_div_q     <= DIV_W'(MOD_TX_DIV_RST);
            tx_en_q      <= 1'b0;
            tx_idle_q    <= 1'b0;
            underrun_q   <= 1'b0;
            overflow_q   <= 1'b0;
            div_cnt_q    <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            data_mod_q   <= 1'b0;
            bit_strobe_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_div_q     <= tx_div_d;
            tx_en_q      <= tx_en_d;
            tx_idle_q    <= tx_idle_d;
            underrun_q   <= underrun_d;
            overflow_q   <= overflow_d;
            div_cnt_q    <= div_cnt_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            data_mod_q   <= data_mod_d;
            bit_strobe_q <= bit_strobe_d;
            ready_q      <= bus.valid;
        end
    end

    // Status word and combinational read mux
    always_comb begin
        busy_c                                  = (state_q == TX_ST_SHIFT);
        status_c                                = '0;
        status_c[STAT_BUSY]                     = busy_c;
        status_c[STAT_FULL]                     = fifo_full_c;
        status_c[STAT_EMPTY]                    = fifo_empty_c;
        status_c[STAT_UNDERRUN]                 = underrun_q;
        status_c[STAT_OVERFLOW]                 = overflow_q;
        status_c[STAT_LEVEL_LSB +: FIFO_AW + 1] = fifo_level;
        case (bus.address)
            ADDR_W'(MOD_TX_DIV):    rdata_c = 32'(tx_div_q);
            ADDR_W'(MOD_TX_EN):     rdata_c = 32'(tx_en_q);
            ADDR_W'(MOD_TX_STATUS): rdata_c = status_c;
            ADDR_W'(MOD_TX_IDLE):   rdata_c = 32'(tx_idle_q);
            default:                rdata_c = MOD_RD_INVALID;
        endcase
    end

    assign bus.rdata  = rdata_c;
    assign bus.ready  = ready_q;
    assign data_mod   = data_mod_q;
    assign bit_strobe = bit_strobe_q;

endmodule

// File: tb/tb_adpll_mod_serializer.sv
// Directed bench: expected serial bits are queued at push time and popped on each bit_strobe.
module tb_adpll_mod_serializer;
    import adpll_mod_serializer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic data_mod;
    logic bit_strobe;

    always #5 clk = ~clk;

    adpll_mod_serializer_if #(.ADDR_W(5)) bus ();

    adpll_mod_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .data_mod   (data_mod),
        .bit_strobe (bit_strobe)
    );

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];
    int   strobe_cyc[$];
    int   cyc = 0;
    int   strobe_cnt = 0;
    int   hold_rem = 0;
    logic cur_bit = 1'b0;
    int   tb_div = 31;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bit monitor: pop expected bit on each strobe, then require it held for TX_DIV+1 cycles
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            hold_rem = 0;
        end else begin
            if (bit_strobe) begin
                strobe_cnt++;
                strobe_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_bit_strobe", 32'(bit_strobe), 32'(0));
                end else begin
                    cur_bit  = exp_q.pop_front();
                    hold_rem = tb_div + 1;
                end
            end
            if (hold_rem > 0) begin
                chk("data_mod_bit", 32'(data_mod), 32'(cur_bit));
                hold_rem--;
            end
        end
    end

    task automatic cpu_write(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.valid   = 1'b1;
        bus.wstrb   = 1'b1;
        bus.address = addr;
        bus.wdata   = data;
        @(posedge clk);
        #1;
        chk("wr_ready", 32'(bus.ready), 32'(1));
        bus.valid = 1'b0;
        bus.wstrb = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        @(negedge clk);
        bus.valid   = 1'b1;
        bus.wstrb   = 1'b0;
        bus.address = addr;
        #1;
        d = bus.rdata;
        chk(tag, d, exp);
        @(posedge clk);
        #1;
        chk("rd_ready", 32'(bus.ready), 32'(1));
        bus.valid = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic expect_tx);
        if (expect_tx) begin
            for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        end
        cpu_write(5'(MOD_TX_DATA), 32'(b));
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int   n;
        logic done;
        n = 0;
        while ((exp_q.size() != 0 || hold_rem != 0) && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        done = (exp_q.size() == 0 && hold_rem == 0);
        chk(tag, 32'(done), 32'(1));
    endtask

    task automatic wait_strobes(input string tag, input int cnt, input int max_cyc);
        int   n;
        logic hit;
        n = 0;
        while (strobe_cnt < cnt && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        hit = (strobe_cnt >= cnt);
        chk(tag, 32'(hit), 32'(1));
    endtask

    task automatic chk_gaps(input string tag, input int gap, input int nbits);
        chk({tag, "_count"}, 32'(strobe_cyc.size()), 32'(nbits));
        for (int i = 1; i < strobe_cyc.size(); i++)
            chk({tag, "_gap"}, 32'(strobe_cyc[i] - strobe_cyc[i-1]), 32'(gap));
    endtask

    task automatic restart_capture();
        strobe_cyc.delete();
        strobe_cnt = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.valid   = 1'b0;
        bus.wstrb   = 1'b0;
        bus.address = '0;
        bus.wdata   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_data_mod", 32'(data_mod), 32'(0));
        chk("rst_bit_strobe", 32'(bit_strobe), 32'(0));
        chk("rst_ready", 32'(bus.ready), 32'(0));
        rst = 1'b0;
        read_chk("rst_tx_div", 5'(MOD_TX_DIV), 32'd31);
        read_chk("rst_status", 5'(MOD_TX_STATUS), 32'h4);
        read_chk("unmapped_31", 5'd31, 32'hFFFF_FFFF);
        read_chk("rd_tx_data_wo", 5'(MOD_TX_DATA), 32'hFFFF_FFFF);
        read_chk("rd_tx_ctrl_wo", 5'(MOD_TX_CTRL), 32'hFFFF_FFFF);
        read_chk("rst_tx_en", 5'(MOD_TX_EN), 32'h0);
        read_chk("rst_tx_idle", 5'(MOD_TX_IDLE), 32'h0);
        chk("idle_data_mod", 32'(data_mod), 32'(0));

        // Single byte 0xA5 at 4 cycles/bit, ending in underrun
        cpu_write(5'(MOD_TX_DIV), 32'd3);
        tb_div = 3;
        read_chk("tx_div_rb", 5'(MOD_TX_DIV), 32'd3);
        push_byte(8'hA5, 1'b1);
        restart_capture();
        cpu_write(5'(MOD_TX_EN), 32'd1);
        wait_done("a5_done", 200);
        chk_gaps("a5", 4, 8);
        repeat (2) @(negedge clk);
        read_chk("a5_status_underrun", 5'(MOD_TX_STATUS), 32'hC);
        chk("a5_idle_level", 32'(data_mod), 32'(0));
        cpu_write(5'(MOD_TX_CTRL), 32'd2);
        read_chk("a5_status_cleared", 5'(MOD_TX_STATUS), 32'h4);

        // Two queued bytes at 2 cycles/bit must run back-to-back
        cpu_write(5'(MOD_TX_EN), 32'd0);
        cpu_write(5'(MOD_TX_DIV), 32'd1);
        tb_div = 1;
        push_byte(8'h0F, 1'b1);
        push_byte(8'hF0, 1'b1);
        read_chk("two_level", 5'(MOD_TX_STATUS), 32'h200);
        restart_capture();
        cpu_write(5'(MOD_TX_EN), 32'd1);
        wait_strobes("two_second_byte", 9, 200);
        cpu_write(5'(MOD_TX_EN), 32'd0);
        wait_done("two_done", 200);
        chk_gaps("two", 2, 16);
        repeat (2) @(negedge clk);
        read_chk("two_status", 5'(MOD_TX_STATUS), 32'h4);

        // Overflow: nine pushes into a depth-8 FIFO with TX disabled
        for (int i = 0; i < 9; i++) push_byte(8'(i), 1'b0);
        read_chk("ovf_status", 5'(MOD_TX_STATUS), 32'h812);
        cpu_write(5'(MOD_TX_CTRL), 32'd2);
        read_chk("ovf_cleared", 5'(MOD_TX_STATUS), 32'h802);
        cpu_write(5'(MOD_TX_CTRL), 32'd1);
        read_chk("flush_status", 5'(MOD_TX_STATUS), 32'h4);

        // TX_EN cleared mid-byte: byte completes, next byte stays queued
        cpu_write(5'(MOD_TX_DIV), 32'd3);
        tb_div = 3;
        push_byte(8'h3C, 1'b1);
        push_byte(8'h81, 1'b0);
        restart_capture();
        cpu_write(5'(MOD_TX_EN), 32'd1);
        wait_strobes("stop_bit3", 4, 100);
        cpu_write(5'(MOD_TX_EN), 32'd0);
        wait_done("stop_done", 200);
        repeat (20) @(negedge clk);
        chk("stop_strobes", 32'(strobe_cnt), 32'd8);
        read_chk("stop_status", 5'(MOD_TX_STATUS), 32'h100);
        cpu_write(5'(MOD_TX_CTRL), 32'd1);
        read_chk("stop_flushed", 5'(MOD_TX_STATUS), 32'h4);

        // Reset asserted mid-byte
        push_byte(8'hFF, 1'b1);
        restart_capture();
        cpu_write(5'(MOD_TX_EN), 32'd1);
        wait_strobes("rst_mid_bits", 3, 100);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_data_mod", 32'(data_mod), 32'(0));
        chk("rst_mid_strobe", 32'(bit_strobe), 32'(0));
        chk("rst_mid_ready", 32'(bus.ready), 32'(0));
        bus.valid   = 1'b1;
        bus.wstrb   = 1'b0;
        bus.address = 5'(MOD_TX_STATUS);
        #1;
        chk("rst_mid_status", bus.rdata, 32'h4);
        bus.valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst    = 1'b0;
        tb_div = 31;
        read_chk("rst_mid_div", 5'(MOD_TX_DIV), 32'd31);
        read_chk("rst_mid_en", 5'(MOD_TX_EN), 32'd0);

        // Idle level high, enabled with an empty FIFO: no activity, no underrun
        cpu_write(5'(MOD_TX_IDLE), 32'd1);
        cpu_write(5'(MOD_TX_EN), 32'd1);
        repeat (10) @(negedge clk);
        chk("idle_hi_data_mod", 32'(data_mod), 32'(1));
        read_chk("idle_hi_status", 5'(MOD_TX_STATUS), 32'h4);
        read_chk("idle_hi_rb", 5'(MOD_TX_IDLE), 32'h1);

        // A zero byte at reset divider returns to the high idle level
        restart_capture();
        push_byte(8'h00, 1'b1);
        wait_done("zero_done", 400);
        repeat (2) @(negedge clk);
        chk("zero_strobes", 32'(strobe_cnt), 32'd8);
        chk("zero_idle_level", 32'(data_mod), 32'(1));
        read_chk("zero_status", 5'(MOD_TX_STATUS), 32'hC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
